// File: rtl/freq_count_scan.sv
// Gated 4-digit BCD edge counter with end-of-window latch and a multiplexed digit scan
// feeding a single 7-segment decoder input.
module freq_count_scan #(
    parameter int GATE_CYCLES = 1000,
    parameter int SCAN_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sig_in,
    output logic [3:0] bcd_out,
    output logic [3:0] digit_sel,
    output logic       overflow,
    output logic       valid
);

    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);

    // Returns {carry_out, value}; carry_out is set only when 9999 rolls over to 0000.
    function automatic logic [16:0] bcd_inc(input logic [15:0] v, input logic inc);
        logic [15:0] r;
        logic        c;
        r = v;
        c = inc;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    function automatic logic [15:0] bcd_sat(input logic [15:0] v, input logic ovf);
        return ovf ? 16'h9999 : v;
    endfunction

    logic              sync1_q, sync2_q, sync3_q, edge_q;
    logic [GATE_W-1:0] gate_q;
    logic [SCAN_W-1:0] scan_q;
    logic [15:0]       cnt_q, latch_q;
    logic              ovf_q, overflow_q, valid_q;
    logic [3:0]        sel_q, bcd_q;

    logic              tc, wrap, ovf_d, scan_wrap;
    logic [15:0]       cnt_inc, latch_d;
    logic [3:0]        sel_d, bcd_d;

    always_comb begin
        {wrap, cnt_inc} = bcd_inc(cnt_q, edge_q);
        tc        = (gate_q == GATE_LAST);
        ovf_d     = ovf_q | wrap;
        latch_d   = tc ? bcd_sat(cnt_inc, ovf_d) : latch_q;
        scan_wrap = (scan_q == SCAN_LAST);
        sel_d     = scan_wrap ? {sel_q[2:0], sel_q[3]} : sel_q;
        // Mux from the next-state latch so a fresh result reaches the bus with valid.
        case (sel_d)
            4'b0001: bcd_d = latch_d[3:0];
            4'b0010: bcd_d = latch_d[7:4];
            4'b0100: bcd_d = latch_d[11:8];
            default: bcd_d = latch_d[15:12];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            edge_q     <= 1'b0;
            gate_q     <= '0;
            scan_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            latch_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            sel_q      <= 4'b0001;
            bcd_q      <= '0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q & ~sync3_q;

            gate_q  <= tc ? '0 : gate_q + GATE_W'(1);
            valid_q <= tc;
            latch_q <= latch_d;
            if (tc) begin
                cnt_q      <= '0;
                ovf_q      <= 1'b0;
                overflow_q <= ovf_d;
            end else begin
                cnt_q <= cnt_inc;
                ovf_q <= ovf_d;
            end

            scan_q <= scan_wrap ? '0 : scan_q + SCAN_W'(1);
            sel_q  <= sel_d;
            bcd_q  <= bcd_d;
        end
    end

    assign bcd_out   = bcd_q;
    assign digit_sel = sel_q;
    assign overflow  = overflow_q;
    assign valid     = valid_q;

endmodule

// File: tb/tb_freq_count_scan.sv
// Directed bench for freq_count_scan: three instances with different gate/scan lengths
// run concurrently from one clock and reset; results are read back through the digit scan.
module tb_freq_count_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sa, sb, sc;
    logic [3:0] bcd [3];
    logic [3:0] sel [3];
    logic       ovf [3];
    logic       vld [3];
    int         pe;
    int         tick = 0;
    int         nvec = 0;
    int         nerr = 0;

    always #5 clk = ~clk;

    freq_count_scan #(.GATE_CYCLES(100), .SCAN_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .sig_in(sa),
        .bcd_out(bcd[0]), .digit_sel(sel[0]), .overflow(ovf[0]), .valid(vld[0]));

    freq_count_scan #(.GATE_CYCLES(3000), .SCAN_CYCLES(4)) u_b (
        .clk(clk), .rst_n(rst_n), .sig_in(sb),
        .bcd_out(bcd[1]), .digit_sel(sel[1]), .overflow(ovf[1]), .valid(vld[1]));

    freq_count_scan #(.GATE_CYCLES(30000), .SCAN_CYCLES(4)) u_c (
        .clk(clk), .rst_n(rst_n), .sig_in(sc),
        .bcd_out(bcd[2]), .digit_sel(sel[2]), .overflow(ovf[2]), .valid(vld[2]));

    // pe = number of rising edges since the last reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pe <= 0;
        else        pe <= pe + 1;
    end

    // Level of each sig_in ahead of rising edge j (j = 1 is the first edge after release).
    function automatic logic fa(input int j);
        if (j <= 197) return (j % 4) >= 2;
        if (j <= 280) return (j >= 200) && (j % 2 == 0);
        return j == 297;
    endfunction

    function automatic logic fb(input int j);
        return (j % 2) == 0;
    endfunction

    function automatic logic fc(input int j);
        if (j <= 29997) return (j % 2) == 0;
        return (j % 4) >= 2;
    endfunction

    initial begin
        sa = 1'b0; sb = 1'b0; sc = 1'b0;
        forever begin
            @(negedge clk);
            tick++;
            if (!rst_n) begin
                sa = tick[0]; sb = tick[0]; sc = tick[0];
            end else begin
                sa = fa(pe + 1); sb = fb(pe + 1); sc = fc(pe + 1);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_vld(input int k, input int exp_pe, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld[k] && n < 70000);
        check_eq(tag, pe, exp_pe);
    endtask

    // Called on the negedge of the valid cycle; collects all four digits through the scan.
    task automatic read_res(input int k, input int s, input string tag,
                            input logic [15:0] exp_val, input logic exp_ovf);
        logic [15:0] got = '0;
        logic        bad = 1'b0;
        logic [3:0]  prev = '0;
        check_eq({tag, "_ovf"}, ovf[k], exp_ovf);
        for (int n = 0; n < 4 * s; n++) begin
            if (n > 0) @(negedge clk);
            if (n == 1) check_eq({tag, "_vldw"}, vld[k], 1'b0);
            case (sel[k])
                4'b0001: got[3:0]   = bcd[k];
                4'b0010: got[7:4]   = bcd[k];
                4'b0100: got[11:8]  = bcd[k];
                4'b1000: got[15:12] = bcd[k];
                default: bad = 1'b1;
            endcase
            if (n > 0) begin
                if (s == 1 && sel[k] != {prev[2:0], prev[3]}) bad = 1'b1;
                if (sel[k] != prev && sel[k] != {prev[2:0], prev[3]}) bad = 1'b1;
            end
            prev = sel[k];
        end
        check_eq({tag, "_val"}, got, exp_val);
        check_eq({tag, "_sel"}, bad, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_bcd", bcd[0], 4'd0);
        check_eq("rst_sel", sel[0], 4'b0001);
        check_eq("rst_ovf", ovf[0], 1'b0);
        check_eq("rst_vld", vld[0], 1'b0);
        check_eq("rst_sel_c", sel[2], 4'b0001);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        fork
            begin
                wait_vld(0, 100, "A_w1_t");
                read_res(0, 1, "A_w1", 16'h0024, 1'b0);
                wait_vld(0, 200, "A_w2_t");
                check_eq("A_w2_sel0", sel[0], 4'b0001);
                check_eq("A_w2_dig0", bcd[0], 4'd5);
                read_res(0, 1, "A_w2", 16'h0025, 1'b0);
                wait_vld(0, 300, "A_tc_t");
                read_res(0, 1, "A_tc", 16'h0042, 1'b0);
                for (int w = 4; w <= 6; w++) begin
                    wait_vld(0, w * 100, $sformatf("A_z%0d_t", w));
                    read_res(0, 1, $sformatf("A_z%0d", w), 16'h0000, 1'b0);
                end
            end
            begin
                wait_vld(1, 3000, "B_w1_t");
                read_res(1, 4, "B_w1", 16'h1498, 1'b0);
                wait_vld(1, 6000, "B_w2_t");
                read_res(1, 4, "B_w2", 16'h1500, 1'b0);
            end
            begin
                wait_vld(2, 30000, "C_w1_t");
                read_res(2, 4, "C_w1", 16'h9999, 1'b1);
                wait_vld(2, 60000, "C_w2_t");
                read_res(2, 4, "C_w2", 16'h7500, 1'b0);
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
